// File: rtl/adder_tb_pkg.sv
// Shared constants for the adder stimulus sequencer: phase encoding,
// corner-table size, LFSR taps, default seeds and the LFSR step function.
package adder_tb_pkg;

    // Phase codes reported on the phase output (DONE reports PH_IDLE)
    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_CORNER = 2'd1;
    localparam logic [1:0] PH_WALK   = 2'd2;
    localparam logic [1:0] PH_RANDOM = 2'd3;

    // Number of entries in the corner-vector table
    localparam int CORNER_COUNT = 8;

    // Feedback taps of the 64-bit Fibonacci LFSR
    localparam int LFSR_TAP0 = 63;
    localparam int LFSR_TAP1 = 62;
    localparam int LFSR_TAP2 = 60;
    localparam int LFSR_TAP3 = 59;

    // Default seeds for the two operand LFSRs
    localparam logic [63:0] DEFAULT_SEED_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] DEFAULT_SEED_B = 64'hFEDCBA9876543210;

    // One shift of the LFSR: XOR of the taps enters at bit 0
    function automatic logic [63:0] lfsr64_step(input logic [63:0] s);
        logic fb;
        fb = s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3];
        return {s[62:0], fb};
    endfunction

endpackage

// File: rtl/adder_stim_gen_lfsr64.sv
// 64-bit Fibonacci LFSR with seed reload and advance enable. An all-zero
// seed would lock the register at zero forever, so it is replaced by 1.
module lfsr64
    import adder_tb_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED_A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [63:0] o_state,
    output logic [63:0] o_next
);

    localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;

    logic [63:0] r_state;

    // Register reloads the seed on reset or load, otherwise steps when asked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED_EFF;
        end else if (i_load) begin
            r_state <= SEED_EFF;
        end else if (i_advance) begin
            r_state <= lfsr64_step(r_state);
        end
    end

    assign o_state = r_state;
    assign o_next  = lfsr64_step(r_state);

endmodule

// File: rtl/adder_stim_gen.sv
// On-chip stimulus sequencer for the adder benches. A run walks through a
// fixed corner table, a carry-chain sweep and LFSR random operands, handing
// each {a,b,cin} downstream over a valid/ready handshake.
module adder_stim_gen
    import adder_tb_pkg::*;
#(
    parameter int          N          = 64,
    parameter int          NUM_RANDOM = 30000,
    parameter logic [63:0] SEED_A     = DEFAULT_SEED_A,
    parameter logic [63:0] SEED_B     = DEFAULT_SEED_B
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ready,
    output logic          valid,
    output logic [N-1:0]  a,
    output logic [N-1:0]  b,
    output logic          cin,
    output logic [1:0]    phase,
    output logic [31:0]   vec_count,
    output logic          done
);

    // Index is wide enough to hold N-1 without wrapping and also covers 0..7
    localparam int IW = $clog2(N) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CORNER = 3'd1;
    localparam logic [2:0] ST_WALK   = 3'd2;
    localparam logic [2:0] ST_RANDOM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [IW-1:0] CORNER_LAST = IW'(CORNER_COUNT - 1);
    localparam logic [IW-1:0] WALK_LAST   = IW'(N - 1);
    localparam logic [31:0]   RND_LAST    = (NUM_RANDOM > 0) ? 32'(NUM_RANDOM - 1) : 32'd0;

    logic [2:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_rndCount;
    logic          r_valid;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_cin;
    logic [1:0]    r_phase;
    logic [31:0]   r_vecCount;
    logic          r_done;

    logic          w_startRun;
    logic          w_xfer;
    logic          w_lfsrAdvance;
    logic [63:0]   w_lfsrA;
    logic [63:0]   w_lfsrANext;
    logic [63:0]   w_lfsrB;
    logic [63:0]   w_lfsrBNext;

    // Corner table packed as {a, b, cin}; ALT5 has ones in the even bits
    function automatic logic [2*N:0] corner_vec(input logic [2:0] idx);
        logic [N-1:0] ones;
        logic [N-1:0] alt5;
        logic [N-1:0] alta;
        logic [2*N:0] v;
        ones = '1;
        for (int j = 0; j < N; j++) begin
            alt5[j] = ((j % 2) == 0);
        end
        alta = ~alt5;
        v    = '0;
        case (idx)
            3'd0:    v = {{N{1'b0}}, {N{1'b0}}, 1'b0};
            3'd1:    v = {{N{1'b0}}, {N{1'b0}}, 1'b1};
            3'd2:    v = {ones, {N{1'b0}}, 1'b1};
            3'd3:    v = {ones, N'(1), 1'b0};
            3'd4:    v = {ones, ones, 1'b0};
            3'd5:    v = {ones, ones, 1'b1};
            3'd6:    v = {alt5, alta, 1'b1};
            default: v = {alta, alta, 1'b0};
        endcase
        return v;
    endfunction

    // Walk vector i: a single one at bit i against ones from bit i upward,
    // so the carry ripples from bit i to the top
    function automatic logic [2*N:0] walk_vec(input logic [IW-1:0] idx);
        logic [N-1:0] ones;
        logic [N-1:0] one;
        ones = '1;
        one  = N'(1);
        return {one << idx, ones << idx, idx[0]};
    endfunction

    // Random vector drawn from the low bits of the two LFSR states
    function automatic logic [2*N:0] random_vec(input logic [63:0] sa, input logic [63:0] sb);
        return {sa[N-1:0], sb[N-1:0], sa[N-1] ^ sb[0]};
    endfunction

    // Start is only honoured when no run is active; a transfer is valid&&ready
    always_comb begin
        w_startRun    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_xfer        = r_valid && ready;
        w_lfsrAdvance = w_xfer && (r_state == ST_RANDOM);
    end

    lfsr64 #(.SEED(SEED_A)) u_lfsrA (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_startRun),
        .i_advance(w_lfsrAdvance),
        .o_state  (w_lfsrA),
        .o_next   (w_lfsrANext)
    );

    lfsr64 #(.SEED(SEED_B)) u_lfsrB (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_startRun),
        .i_advance(w_lfsrAdvance),
        .o_state  (w_lfsrB),
        .o_next   (w_lfsrBNext)
    );

    // Sequencer: loads the next vector on the edge after each transfer and
    // holds everything stable while the downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_rndCount <= '0;
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_phase    <= PH_IDLE;
            r_vecCount <= '0;
            r_done     <= 1'b0;
        end else if (w_startRun) begin
            r_state             <= ST_CORNER;
            r_idx               <= '0;
            r_rndCount          <= '0;
            r_valid             <= 1'b1;
            {r_a, r_b, r_cin}   <= corner_vec(3'd0);
            r_phase             <= PH_CORNER;
            r_vecCount          <= '0;
            r_done              <= 1'b0;
        end else if (w_xfer) begin
            if (r_vecCount != 32'hFFFF_FFFF) begin
                r_vecCount <= r_vecCount + 32'd1;
            end
            case (r_state)
                ST_CORNER: begin
                    if (r_idx == CORNER_LAST) begin
                        r_state           <= ST_WALK;
                        r_idx             <= '0;
                        {r_a, r_b, r_cin} <= walk_vec('0);
                        r_phase           <= PH_WALK;
                    end else begin
                        r_idx             <= r_idx + 1'b1;
                        {r_a, r_b, r_cin} <= corner_vec(r_idx[2:0] + 3'd1);
                    end
                end
                ST_WALK: begin
                    if (r_idx == WALK_LAST) begin
                        if (NUM_RANDOM == 0) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_phase <= PH_IDLE;
                        end else begin
                            r_state           <= ST_RANDOM;
                            r_phase           <= PH_RANDOM;
                            {r_a, r_b, r_cin} <= random_vec(w_lfsrA, w_lfsrB);
                        end
                    end else begin
                        r_idx             <= r_idx + 1'b1;
                        {r_a, r_b, r_cin} <= walk_vec(r_idx + 1'b1);
                    end
                end
                ST_RANDOM: begin
                    if (r_rndCount == RND_LAST) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_phase <= PH_IDLE;
                    end else begin
                        r_rndCount        <= r_rndCount + 32'd1;
                        {r_a, r_b, r_cin} <= random_vec(w_lfsrANext, w_lfsrBNext);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid     = r_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign cin       = r_cin;
    assign phase     = r_phase;
    assign vec_count = r_vecCount;
    assign done      = r_done;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Self-checking bench for adder_stim_gen: a default 64-bit instance runs the
// full sequence against a scoreboard, a small N=8 instance covers the
// zero-seed guard and short run length.
module tb_adder_stim_gen;

    localparam int TOTAL = 8 + 64 + 30000;

    typedef struct packed {
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [1:0]  ph;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ALT5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] ALTA = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [1:0]  phase;
    logic [31:0] vecCount;
    logic        done;

    logic        sStart;
    logic        sReady;
    logic        sValid;
    logic [7:0]  sA;
    logic [7:0]  sB;
    logic        sCin;
    logic [1:0]  sPhase;
    logic [31:0] sVecCount;
    logic        sDone;

    int          checks;
    int          failures;
    int          xferCount;
    vec_t        sb[$];
    logic [63:0] mA;
    logic [63:0] mB;

    adder_stim_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .valid    (valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .phase    (phase),
        .vec_count(vecCount),
        .done     (done)
    );

    adder_stim_gen #(.N(8), .NUM_RANDOM(4), .SEED_A(64'h0)) dutSmall (
        .clk      (clk),
        .rst      (rst),
        .start    (sStart),
        .ready    (sReady),
        .valid    (sValid),
        .a        (sA),
        .b        (sB),
        .cin      (sCin),
        .phase    (sPhase),
        .vec_count(sVecCount),
        .done     (sDone)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // Expected corner (k<8) or walk (k=8..71) vector for the 64-bit instance
    function automatic vec_t model_fixed(input int k);
        vec_t v;
        int   i;
        v = '0;
        v.v = 1'b1;
        if (k < 8) begin
            v.ph = 2'd1;
            case (k)
                0: begin v.a = 64'h0; v.b = 64'h0; v.cin = 1'b0; end
                1: begin v.a = 64'h0; v.b = 64'h0; v.cin = 1'b1; end
                2: begin v.a = ONES;  v.b = 64'h0; v.cin = 1'b1; end
                3: begin v.a = ONES;  v.b = 64'h1; v.cin = 1'b0; end
                4: begin v.a = ONES;  v.b = ONES;  v.cin = 1'b0; end
                5: begin v.a = ONES;  v.b = ONES;  v.cin = 1'b1; end
                6: begin v.a = ALT5;  v.b = ALTA;  v.cin = 1'b1; end
                default: begin v.a = ALTA; v.b = ALTA; v.cin = 1'b0; end
            endcase
        end else begin
            i     = k - 8;
            v.ph  = 2'd2;
            v.a   = 64'd1 << i;
            v.b   = ONES & ~((64'd1 << i) - 64'd1);
            v.cin = i[0];
        end
        return v;
    endfunction

    // Pulse start for one cycle and load the scoreboard with the fixed phases
    task automatic do_start();
        ready = 1'b0;
        start = 1'b1;
        sb.delete();
        for (int k = 0; k < 72; k++) begin
            sb.push_back(model_fixed(k));
        end
        mA        = 64'h0123456789ABCDEF;
        mB        = 64'hFEDCBA9876543210;
        xferCount = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive ready for one transfer, returning what was shown and what was due
    task automatic accept_vec(output vec_t got, output vec_t exp);
        ready = 1'b1;
        got   = {valid, a, b, cin, phase};
        if (sb.size() == 0) begin
            sb.push_back({1'b1, mA, mB, mA[63] ^ mB[0], 2'd3});
            mA = lfsr_next(mA);
            mB = lfsr_next(mB);
        end
        exp = sb.pop_front();
        xferCount++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t got;
        vec_t exp;
        rst    = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        sStart = 1'b0;
        sReady = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, phase, vecCount, done} !== 35'd0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got valid=%b phase=%0d count=%0d done=%b, expected all 0",
                     valid, phase, vecCount, done);
        end
        do_start();
        for (int k = 0; k < 3; k++) begin
            accept_vec(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL pre_reset_vec[%0d]: got %h expected %h", k, got, exp);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, a, b, cin, phase, vecCount, done} !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%b a=%h b=%h cin=%b phase=%0d count=%0d done=%b, expected all 0",
                     valid, a, b, cin, phase, vecCount, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        checks++;
        if ({valid, a, b, cin, phase} !== {1'b1, 64'h0, 64'h0, 1'b0, 2'd1}) begin
            failures++;
            $display("[TB] FAIL first_vec: got valid=%b a=%h b=%h cin=%b phase=%0d, expected 1 0 0 0 1",
                     valid, a, b, cin, phase);
        end
    endtask

    task automatic test_backpressure();
        vec_t got;
        vec_t exp;
        for (int k = 0; k < 3; k++) begin
            accept_vec(got, exp);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL bp_vec[%0d]: got %h expected %h", k, got, exp);
            end
            if (k == 2) begin
                checks++;
                if ({got.a, got.b, got.cin} !== {ONES, 64'h0, 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL transfer2: got a=%h b=%h cin=%b, expected ones 0 1", got.a, got.b, got.cin);
                end
            end
        end
        ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if ({valid, a, b, cin, phase, vecCount} !== {1'b1, ONES, 64'h1, 1'b0, 2'd1, 32'd3}) begin
                failures++;
                $display("[TB] FAIL stall[%0d]: got valid=%b a=%h b=%h cin=%b phase=%0d count=%0d",
                         c, valid, a, b, cin, phase, vecCount);
            end
        end
        accept_vec(got, exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL bp_release: got %h expected %h", got, exp);
        end
        checks++;
        if ({valid, a, b, cin, vecCount} !== {1'b1, ONES, ONES, 1'b0, 32'd4}) begin
            failures++;
            $display("[TB] FAIL after_stall: got a=%h b=%h cin=%b count=%0d, expected entry 4 count 4",
                     a, b, cin, vecCount);
        end
    endtask

    task automatic test_corner_walk();
        vec_t got;
        vec_t exp;
        int   k;
        while (xferCount < 72) begin
            k = xferCount;
            if (k == 20) start = 1'b1;
            accept_vec(got, exp);
            start = 1'b0;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL fixed_vec[%0d]: got %h expected %h", k, got, exp);
            end
            checks++;
            if (vecCount !== 32'(xferCount)) begin
                failures++;
                $display("[TB] FAIL fixed_count[%0d]: got %0d expected %0d", k, vecCount, xferCount);
            end
            if (k == 8) begin
                checks++;
                if ({got.a, got.b, got.cin} !== {64'h1, ONES, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL walk0: got a=%h b=%h cin=%b", got.a, got.b, got.cin);
                end
            end
            if (k == 13) begin
                checks++;
                if ({got.a, got.b, got.cin} !== {64'h20, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL walk5: got a=%h b=%h cin=%b", got.a, got.b, got.cin);
                end
            end
        end
    endtask

    task automatic test_random();
        vec_t got;
        vec_t exp;
        int   bad;
        int   firstBad;
        int   early;
        accept_vec(got, exp);
        checks++;
        if (got !== {1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 2'd3}) begin
            failures++;
            $display("[TB] FAIL random0: got %h", got);
        end
        accept_vec(got, exp);
        checks++;
        if (got.a !== 64'h02468ACF13579BDE || got !== exp) begin
            failures++;
            $display("[TB] FAIL random1: got %h expected %h", got, exp);
        end
        bad      = 0;
        firstBad = -1;
        early    = 0;
        while (xferCount < TOTAL) begin
            accept_vec(got, exp);
            if (got !== exp) begin
                bad++;
                if (firstBad < 0) firstBad = xferCount - 1;
            end
            if (done && xferCount < TOTAL) early++;
        end
        ready = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL random_stream: %0d bad vectors, first at transfer %0d, expected 0", bad, firstBad);
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("[TB] FAIL done_early: done seen %0d times before transfer %0d", early, TOTAL);
        end
        checks++;
        if ({done, valid, phase, vecCount} !== {1'b1, 1'b0, 2'd0, 32'(TOTAL)}) begin
            failures++;
            $display("[TB] FAIL run_end: got done=%b valid=%b phase=%0d count=%0d, expected 1 0 0 %0d",
                     done, valid, phase, vecCount, TOTAL);
        end
    endtask

    task automatic test_restart();
        vec_t got;
        vec_t exp;
        repeat (3) @(negedge clk);
        checks++;
        if ({done, valid} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL done_hold: got done=%b valid=%b, expected 1 0", done, valid);
        end
        do_start();
        checks++;
        if ({valid, a, b, cin, phase, vecCount, done} !== {1'b1, 64'h0, 64'h0, 1'b0, 2'd1, 32'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL restart: got valid=%b a=%h b=%h cin=%b phase=%0d count=%0d done=%b",
                     valid, a, b, cin, phase, vecCount, done);
        end
        accept_vec(got, exp);
        ready = 1'b0;
        checks++;
        if (got !== exp || vecCount !== 32'd1) begin
            failures++;
            $display("[TB] FAIL restart_xfer: got %h count=%0d expected %h count=1", got, vecCount, exp);
        end
    endtask

    task automatic test_small();
        int         cnt;
        int         guard;
        logic [7:0] firstA;
        logic [7:0] firstB;
        logic       firstCin;
        logic [7:0] alt5Seen;
        cnt      = 0;
        guard    = 0;
        firstA   = 8'hXX;
        firstB   = 8'hXX;
        firstCin = 1'bx;
        alt5Seen = 8'hXX;
        sStart   = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        sReady = 1'b1;
        while (!sDone && guard < 200) begin
            if (sValid) begin
                if (cnt == 6)  alt5Seen = sA;
                if (cnt == 16) begin
                    firstA   = sA;
                    firstB   = sB;
                    firstCin = sCin;
                end
                cnt++;
            end
            guard++;
            @(negedge clk);
        end
        sReady = 1'b0;
        checks++;
        if (!sDone) begin
            failures++;
            $display("[TB] FAIL small_timeout: done not seen after %0d cycles", guard);
        end
        checks++;
        if (cnt != 20 || sVecCount !== 32'd20 || sValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL small_total: got transfers=%0d count=%0d valid=%b, expected 20 20 0",
                     cnt, sVecCount, sValid);
        end
        checks++;
        if ({firstA, firstB, firstCin} !== {8'h01, 8'h10, 1'b0}) begin
            failures++;
            $display("[TB] FAIL small_random0: got a=%h b=%h cin=%b, expected 01 10 0", firstA, firstB, firstCin);
        end
        checks++;
        if (alt5Seen !== 8'h55) begin
            failures++;
            $display("[TB] FAIL small_alt5: got %h expected 55", alt5Seen);
        end
    endtask

    // Scenario sequence, then the one-line summary
    initial begin
        checks    = 0;
        failures  = 0;
        xferCount = 0;
        test_reset();
        test_backpressure();
        test_corner_walk();
        test_random();
        test_restart();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_stim_gen.md
Name: adder_stim_gen

Overview:
Synthesizable stimulus sequencer. It sits directly upstream of the adder under test and the reference adder in the adder benches. It replaces file-driven stimulus with three on-chip phases: a corner-vector table, a walking carry-chain sweep, and LFSR random operands. Operands {cin,a,b} are presented through a valid/ready handshake, so the downstream compare/log stage can apply backpressure.

Parameters:
N, 64, operand width; legal range 4..64.
NUM_RANDOM, 30000, number of random vectors in phase 3.
SEED_A, 64'h0123456789ABCDEF, LFSR A seed; value 0 is replaced by 64'h1.
SEED_B, 64'hFEDCBA9876543210, LFSR B seed; value 0 is replaced by 64'h1.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
ready  in  1  downstream accepts the current vector.
valid  out  1  a, b and cin hold a vector.
a  out  N  operand A.
b  out  N  operand B.
cin  out  1  carry-in.
phase  out  2  0=IDLE, 1=CORNER, 2=WALK, 3=RANDOM (DONE reports 0).
vec_count  out  32  number of vectors accepted in the current run.
done  out  1  high after the last vector is accepted; stays high until the next start or rst.

Behaviour:
- Reset (asynchronous assert): state=IDLE; valid=0; a=0; b=0; cin=0; vec_count=0; done=0; phase=0; both LFSRs reload from their seeds; index=0. This applies mid-run: the run is aborted and nothing is resumed.
- All outputs are registered.
- A transfer occurs on a rising edge with valid&&ready.
- While valid&&!ready, a, b, cin and phase are held bit-stable.
- start is ignored in CORNER, WALK and RANDOM.
- start in IDLE or DONE at edge t:
  - valid=1 at t+1, carrying corner vector 0.
  - vec_count and done are cleared; LFSRs reload from seeds.
- The next vector appears on the edge after a transfer, so throughput is 1 vector/cycle when ready is held high.
- FSM: IDLE -start-> CORNER -8th transfer-> WALK -Nth transfer-> RANDOM -NUM_RANDOM-th transfer-> DONE -start-> CORNER. If NUM_RANDOM=0, WALK goes straight to DONE.
- On the edge of the final transfer: valid=0, done=1.
- Corner table, entries 0..7 as (a,b,cin). ONES = all-ones N bits; ALT5 = 0101..01 pattern; ALTA = ~ALT5.
  - 0: (0,0,0)
  - 1: (0,0,1)
  - 2: (ONES,0,1)
  - 3: (ONES,1,0)
  - 4: (ONES,ONES,0)
  - 5: (ONES,ONES,1)
  - 6: (ALT5,ALTA,1)
  - 7: (ALTA,ALTA,0)
- Walk vector i, for i=0..N-1: a = 1<<i; b = ONES & ~((1<<i)-1); cin = i[0]. This produces a full carry ripple from bit i.
- Random phase:
  - Two 64-bit Fibonacci LFSRs: fb = s[63]^s[62]^s[60]^s[59]; next = {s[62:0],fb}.
  - Vector: a = A[N-1:0]; b = B[N-1:0]; cin = A[N-1]^B[0].
  - Both LFSRs advance once per random-phase transfer only. The first random vector therefore uses the seeds.
- vec_count increments by 1 per transfer in every phase and saturates at 2^32-1.
- Run total = 8 + N + NUM_RANDOM (30072 at defaults).
- The walk index is clog2(N)+1 bits wide, so i=N-1 does not wrap.

Decomposition:
- Shared package adder_tb_pkg:
  - phase encoding constants (PH_IDLE, PH_CORNER, PH_WALK, PH_RANDOM);
  - CORNER_COUNT=8;
  - LFSR tap constants;
  - default seeds.
- Corner-table generation is a function of N inside the block.
- One natural sub-module: lfsr64. It has seed load, an advance enable and a zero-seed guard, and is instantiated twice (A and B).

Test Plan:
- rst asserted mid-clock, then released: all outputs 0 immediately, before the next clk edge; start pulse -> next cycle valid=1, a=0, b=0, cin=0, phase=1.
- ready held 1, N=64: transfer 2 is a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1. Transfer 8 (walk i=0) is a=1, b=ONES, cin=0. Walk i=5 is a=64'h20, b=64'hFFFF_FFFF_FFFF_FFE0, cin=1.
- ready=0 for 7 cycles during corner entry 3: a, b, cin and phase stable for all 7 cycles; vec_count unchanged; the next entry appears 1 cycle after ready=1.
- First random vector: a=64'h0123456789ABCDEF, b=64'hFEDCBA9876543210, cin=0. Second vector: a=64'h02468ACF13579BDE.
- Full run with ready=1: done rises exactly 30072 transfers after start; then valid=0 and vec_count=30072. A start pulse mid-run is ignored. A start pulse in DONE restarts with corner vector 0 and vec_count=0.
- N=8, NUM_RANDOM=4, SEED_A=0: LFSR A uses 1, so the first random vector has a=8'h01. Total 20 transfers, then done=1.
